// File: rtl/puf_soc_ser_pkg.sv
// Shared types and width helpers for the PUF/debug frame serializer.
// Bit-order encoding matches the i_msb_first pin directly.
package puf_soc_ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam logic LSB_FIRST = 1'b0;
  localparam logic MSB_FIRST = 1'b1;

  function automatic int len_w(input int fram_size);
    return $clog2(fram_size + 1);
  endfunction

  function automatic int cnt_w(input int fram_size, input int lanes);
    return $clog2(fram_size / lanes + 1);
  endfunction

endpackage

// File: rtl/puf_soc_ser_hold.sv
// One-entry valid/ready holding register; ready is a flop (=empty), 1-cycle load latency.
// Upstream stalls while full; the entry drains when the consumer pulls out_rdy.
module puf_soc_ser_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  logic         full_q, full_d;
  logic         rdy_q, rdy_d;
  logic [W-1:0] dat_q, dat_d;

  always_comb begin
    full_d = full_q;
    dat_d  = dat_q;
    if (out_rdy && full_q) begin
      full_d = 1'b0;
    end
    if (in_vld && rdy_q) begin
      full_d = 1'b1;
      dat_d  = in_dat;
    end
    // ready tracks the next occupancy so a drain reopens the slot one cycle later
    rdy_d = ~full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      rdy_q  <= 1'b1;
      dat_q  <= '0;
    end else begin
      full_q <= full_d;
      rdy_q  <= rdy_d;
      dat_q  <= dat_d;
    end
  end

  assign in_rdy  = rdy_q;
  assign out_vld = full_q;
  assign out_dat = dat_q;

endmodule

// File: rtl/puf_soc_serializer.sv
// Double-buffered parallel-to-serial converter; load-to-first-beat 2 cycles, registered outputs.
// Beats hold while i_tx_ready=0; i_tx_en=0 stops new beats and frame transfers from the buffer.
module puf_soc_serializer
  import puf_soc_ser_pkg::*;
#(
  parameter int FRAM_SIZE = 160,
  parameter int LANES     = 1,
  parameter int LEN_W     = len_w(FRAM_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_tx_en,
  input  logic                 i_msb_first,
  input  logic [LEN_W-1:0]     i_ld_len,
  input  logic                 i_ld_valid,
  input  logic [FRAM_SIZE-1:0] i_ld_data,
  output logic                 o_ld_ready,
  output logic                 o_tx_valid,
  output logic [LANES-1:0]     o_tx_data,
  output logic                 o_tx_last,
  input  logic                 i_tx_ready,
  output logic                 o_tx_done,
  output logic                 o_busy
);

  localparam int                   CNT_W    = cnt_w(FRAM_SIZE, LANES);
  localparam int                   HW       = FRAM_SIZE + LEN_W + 1;
  localparam logic [LEN_W-1:0]     FRAM_LEN = LEN_W'(FRAM_SIZE);
  localparam logic [FRAM_SIZE-1:0] ONES     = '1;

  logic                 h_vld, h_drain;
  logic [HW-1:0]        h_dat;
  logic                 h_msb;
  logic [LEN_W-1:0]     h_len;
  logic [FRAM_SIZE-1:0] h_data;

  puf_soc_ser_hold #(.W(HW)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (i_ld_valid),
    .in_rdy  (o_ld_ready),
    .in_dat  ({i_msb_first, i_ld_len, i_ld_data}),
    .out_vld (h_vld),
    .out_rdy (h_drain),
    .out_dat (h_dat)
  );

  assign h_msb  = h_dat[HW-1];
  assign h_len  = h_dat[FRAM_SIZE +: LEN_W];
  assign h_data = h_dat[FRAM_SIZE-1:0];

  // Normalise the buffered frame so beat k always comes from the low lanes after k shifts,
  // with every bit at or above len already forced to zero.
  logic [LEN_W-1:0]     len_eff;
  logic [FRAM_SIZE-1:0] rev, mask, norm;
  logic [CNT_W-1:0]     ld_last_idx;

  always_comb begin
    len_eff = (h_len == '0 || h_len > FRAM_LEN) ? FRAM_LEN : h_len;
    for (int i = 0; i < FRAM_SIZE; i++) begin
      rev[i] = h_data[FRAM_SIZE-1-i];
    end
    mask        = ~(ONES << len_eff);
    norm        = ((h_msb == MSB_FIRST) ? (rev >> (FRAM_LEN - len_eff)) : h_data) & mask;
    ld_last_idx = CNT_W'((int'(len_eff) + LANES - 1) / LANES - 1);
  end

  ser_state_e           state_q, state_d;
  logic [FRAM_SIZE-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]     beat_q, beat_d;
  logic [CNT_W-1:0]     last_idx_q, last_idx_d;
  logic                 tx_vld_q, tx_vld_d;
  logic [LANES-1:0]     tx_dat_q, tx_dat_d;
  logic                 tx_last_q, tx_last_d;
  logic                 done_q, done_d;
  logic                 launch, do_load, do_adv, do_stop;

  assign launch = h_vld & i_tx_en;

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    beat_d     = beat_q;
    last_idx_d = last_idx_q;
    tx_vld_d   = tx_vld_q;
    tx_dat_d   = tx_dat_q;
    tx_last_d  = tx_last_q;
    done_d     = 1'b0;
    h_drain    = 1'b0;
    do_load    = 1'b0;
    do_adv     = 1'b0;
    do_stop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (launch) do_load = 1'b1;
      end
      SHIFT: begin
        if (tx_vld_q && i_tx_ready) begin
          if (tx_last_q) begin
            done_d = 1'b1;
            if (launch) do_load = 1'b1;
            else        do_stop = 1'b1;
          end else if (i_tx_en) begin
            do_adv = 1'b1;
          end else begin
            tx_vld_d = 1'b0;
          end
        end else if (!tx_vld_q && i_tx_en) begin
          do_adv = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_load) begin
      state_d    = SHIFT;
      h_drain    = 1'b1;
      beat_d     = '0;
      last_idx_d = ld_last_idx;
      tx_vld_d   = 1'b1;
      tx_dat_d   = norm[LANES-1:0];
      tx_last_d  = (ld_last_idx == '0);
      sreg_d     = norm >> LANES;
    end
    if (do_adv) begin
      beat_d    = beat_q + 1'b1;
      tx_vld_d  = 1'b1;
      tx_dat_d  = sreg_q[LANES-1:0];
      tx_last_d = (beat_d == last_idx_q);
      sreg_d    = sreg_q >> LANES;
    end
    if (do_stop) begin
      state_d   = IDLE;
      tx_vld_d  = 1'b0;
      tx_dat_d  = '0;
      tx_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      beat_q     <= '0;
      last_idx_q <= '0;
      tx_vld_q   <= 1'b0;
      tx_dat_q   <= '0;
      tx_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      beat_q     <= beat_d;
      last_idx_q <= last_idx_d;
      tx_vld_q   <= tx_vld_d;
      tx_dat_q   <= tx_dat_d;
      tx_last_q  <= tx_last_d;
      done_q     <= done_d;
    end
  end

  assign o_tx_valid = tx_vld_q;
  assign o_tx_data  = tx_dat_q;
  assign o_tx_last  = tx_last_q;
  assign o_tx_done  = done_q;
  assign o_busy     = (state_q == SHIFT) | h_vld;

endmodule

// File: tb/tb_puf_soc_serializer.sv
// Directed bench for puf_soc_serializer at FRAM_SIZE=16, LANES=4.
// A negedge monitor logs every beat handshake and done pulse with its cycle number.
module tb_puf_soc_serializer;
  import puf_soc_ser_pkg::*;

  localparam int FS = 16;
  localparam int LN = 4;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tx_en = 1'b1;
  logic          msb = 1'b0;
  logic          ld_vld = 1'b0;
  logic          tx_rdy = 1'b1;
  logic [LW-1:0] ld_len = '0;
  logic [FS-1:0] ld_dat = '0;
  logic          o_ld_ready, o_tx_valid, o_tx_last, o_tx_done, o_busy;
  logic [LN-1:0] o_tx_data;

  puf_soc_serializer #(.FRAM_SIZE(FS), .LANES(LN)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_tx_en     (tx_en),
    .i_msb_first (msb),
    .i_ld_len    (ld_len),
    .i_ld_valid  (ld_vld),
    .i_ld_data   (ld_dat),
    .o_ld_ready  (o_ld_ready),
    .o_tx_valid  (o_tx_valid),
    .o_tx_data   (o_tx_data),
    .o_tx_last   (o_tx_last),
    .i_tx_ready  (tx_rdy),
    .o_tx_done   (o_tx_done),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  logic [LN-1:0] beat_log[$];
  logic          last_log[$];
  int            bcyc_log[$];
  int            done_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_tx_valid && tx_rdy) begin
        beat_log.push_back(o_tx_data);
        last_log.push_back(o_tx_last);
        bcyc_log.push_back(cyc);
      end
      if (o_tx_done) done_log.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [FS-1:0] d, input logic [LW-1:0] l, input logic m);
    logic rdy;
    int   t;
    ld_dat = d;
    ld_len = l;
    msb    = m;
    ld_vld = 1'b1;
    for (t = 0; t < 50; t++) begin
      rdy = o_ld_ready;
      step();
      if (rdy) break;
    end
    ld_vld = 1'b0;
    if (t == 50) chk("load_timeout", 0, 1);
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_log.size() < target && t < 200) begin
      step();
      t++;
    end
    if (done_log.size() < target) chk("done_timeout", done_log.size(), target);
    step();
  endtask

  task automatic chk_frame(input string tag, input int base, input int n,
                           input logic [31:0] exp, input logic [7:0] lastm);
    chk({tag, "_nbeats"}, beat_log.size() - base, n);
    for (int k = 0; k < n; k++) begin
      if (base + k < beat_log.size()) begin
        chk($sformatf("%s_dat%0d", tag, k), beat_log[base+k], exp[4*k +: 4]);
        chk($sformatf("%s_last%0d", tag, k), last_log[base+k], lastm[k]);
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ld_ready"}, o_ld_ready, 1);
    chk({tag, "_tx_valid"}, o_tx_valid, 0);
    chk({tag, "_tx_data"}, o_tx_data, 0);
    chk({tag, "_tx_last"}, o_tx_last, 0);
    chk({tag, "_tx_done"}, o_tx_done, 0);
    chk({tag, "_busy"}, o_busy, 0);
  endtask

  initial begin
    int b, d0;
    step();
    step();
    chk_reset_outputs("rst");
    rst = 1'b0;
    step();

    // 1: LSB-first full frame, latency and done timing
    b = beat_log.size(); d0 = done_log.size();
    load(16'hA5C3, 5'd16, LSB_FIRST);
    chk("t1_lat1_valid", o_tx_valid, 0);
    chk("t1_lat1_busy", o_busy, 1);
    step();
    chk("t1_lat2_valid", o_tx_valid, 1);
    chk("t1_lat2_data", o_tx_data, 4'h3);
    wait_done(d0 + 1);
    chk_frame("t1", b, 4, 32'h0000A5C3, 8'b0000_1000);
    if (done_log.size() > d0 && beat_log.size() >= b + 4)
      chk("t1_done_delay", done_log[d0] - bcyc_log[b+3], 1);

    // 2: MSB-first
    b = beat_log.size(); d0 = done_log.size();
    load(16'hA5C3, 5'd16, MSB_FIRST);
    wait_done(d0 + 1);
    chk_frame("t2", b, 4, 32'h0000C3A5, 8'b0000_1000);
    chk("t2_busy_after", o_busy, 0);
    chk("t2_ld_ready_after", o_ld_ready, 1);

    // 3: short frame and len=0
    b = beat_log.size(); d0 = done_log.size();
    load(16'h003F, 5'd6, LSB_FIRST);
    wait_done(d0 + 1);
    chk_frame("t3_len6", b, 2, 32'h0000003F, 8'b0000_0010);
    b = beat_log.size(); d0 = done_log.size();
    load(16'hA5C3, 5'd0, LSB_FIRST);
    wait_done(d0 + 1);
    chk_frame("t3_len0", b, 4, 32'h0000A5C3, 8'b0000_1000);

    // 4: back-to-back frames
    b = beat_log.size(); d0 = done_log.size();
    load(16'h1234, 5'd16, LSB_FIRST);
    load(16'h5678, 5'd16, LSB_FIRST);
    chk("t4_ld_ready_full", o_ld_ready, 0);
    chk("t4_busy", o_busy, 1);
    wait_done(d0 + 2);
    chk_frame("t4", b, 8, 32'h56781234, 8'b1000_1000);
    for (int k = 1; k < 8; k++) begin
      if (b + k < bcyc_log.size())
        chk($sformatf("t4_gap%0d", k), bcyc_log[b+k] - bcyc_log[b+k-1], 1);
    end
    chk("t4_done_pulses", done_log.size() - d0, 2);

    // 5: backpressure and tx_en stall
    b = beat_log.size(); d0 = done_log.size();
    load(16'hA5C3, 5'd16, LSB_FIRST);
    step();
    step();
    chk("t5_beat2_data", o_tx_data, 4'hC);
    tx_rdy = 1'b0;
    step();
    chk("t5_hold1_valid", o_tx_valid, 1);
    chk("t5_hold1_data", o_tx_data, 4'hC);
    step();
    chk("t5_hold2_data", o_tx_data, 4'hC);
    tx_rdy = 1'b1;
    tx_en  = 1'b0;
    step();
    chk("t5_stall1_valid", o_tx_valid, 0);
    step();
    chk("t5_stall2_valid", o_tx_valid, 0);
    step();
    chk("t5_stall3_valid", o_tx_valid, 0);
    tx_en = 1'b1;
    step();
    chk("t5_resume_valid", o_tx_valid, 1);
    chk("t5_resume_data", o_tx_data, 4'h5);
    wait_done(d0 + 1);
    chk_frame("t5", b, 4, 32'h0000A5C3, 8'b0000_1000);

    // 6: reset mid-frame
    d0 = done_log.size();
    load(16'hA5C3, 5'd16, LSB_FIRST);
    step();
    step();
    step();
    chk("t6_beat3_data", o_tx_data, 4'h5);
    rst = 1'b1;
    step();
    chk_reset_outputs("t6_rst");
    rst = 1'b0;
    step();
    step();
    chk("t6_no_done", done_log.size(), d0);
    b = beat_log.size();
    load(16'h1234, 5'd16, LSB_FIRST);
    wait_done(d0 + 1);
    chk_frame("t6_post", b, 4, 32'h00001234, 8'b0000_1000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
